// File: rtl/expr_stream_ctrl.sv
// Frames a ';'-terminated character stream into arithmetic expressions and checks nesting/grammar.
// One character per cycle in SCAN; verdict appears the cycle after TERM and is held until res_ready.
module expr_stream_ctrl #(
  parameter int LEN_W   = 8,
  parameter int DEPTH_W = 3
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             res_valid,
  output logic             res_ok,
  output logic [LEN_W-1:0] res_len,
  input  logic             res_ready,
  output logic [15:0]      ok_count
);

  typedef enum logic {SCAN, REPORT} top_e;
  typedef enum logic [1:0] {EXP, AFT, ERR} sub_e;

  localparam logic [LEN_W-1:0]   LEN_MAX   = {LEN_W{1'b1}};
  localparam logic [DEPTH_W-1:0] DEPTH_MAX = {DEPTH_W{1'b1}};

  top_e               state_q, state_d;
  sub_e               sub_q, sub_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               res_ok_q, res_ok_d;
  logic [LEN_W-1:0]   res_len_q, res_len_d;
  logic [15:0]        ok_count_q, ok_count_d;

  logic is_digit, is_op, is_lp, is_rp, is_term, accept, verdict;

  assign is_digit = (in_data >= 8'h30) && (in_data <= 8'h39);
  assign is_op    = (in_data == 8'h2B) || (in_data == 8'h2A);
  assign is_lp    = (in_data == 8'h28);
  assign is_rp    = (in_data == 8'h29);
  assign is_term  = (in_data == 8'h3B);
  assign accept   = in_valid && (state_q == SCAN);
  assign verdict  = (sub_q == AFT) && (depth_q == '0);

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q    <= SCAN;
      sub_q      <= EXP;
      depth_q    <= '0;
      len_q      <= '0;
      res_ok_q   <= 1'b0;
      res_len_q  <= '0;
      ok_count_q <= '0;
    end else begin
      state_q    <= state_d;
      sub_q      <= sub_d;
      depth_q    <= depth_d;
      len_q      <= len_d;
      res_ok_q   <= res_ok_d;
      res_len_q  <= res_len_d;
      ok_count_q <= ok_count_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sub_d      = sub_q;
    depth_d    = depth_q;
    len_d      = len_q;
    res_ok_d   = res_ok_q;
    res_len_d  = res_len_q;
    ok_count_d = ok_count_q;
    case (state_q)
      SCAN: begin
        if (accept) begin
          if (is_term) begin
            state_d   = REPORT;
            res_ok_d  = verdict;
            res_len_d = len_q;
            if (verdict) ok_count_d = ok_count_q + 16'd1;
          end else begin
            if (len_q != LEN_MAX) len_d = len_q + 1'b1;
            // ERR absorbs everything until the terminator
            case (sub_q)
              EXP: begin
                if (is_digit) sub_d = AFT;
                else if (is_lp && depth_q != DEPTH_MAX) depth_d = depth_q + 1'b1;
                else sub_d = ERR;
              end
              AFT: begin
                if (is_op) sub_d = EXP;
                else if (is_rp && depth_q != '0) depth_d = depth_q - 1'b1;
                else sub_d = ERR;
              end
              default: sub_d = ERR;
            endcase
          end
        end
      end
      default: begin
        if (res_ready) begin
          state_d = SCAN;
          sub_d   = EXP;
          depth_d = '0;
          len_d   = '0;
        end
      end
    endcase
  end

  always_comb begin
    in_ready  = (state_q == SCAN);
    res_valid = (state_q == REPORT);
    res_ok    = res_ok_q;
    res_len   = res_len_q;
    ok_count  = ok_count_q;
  end

endmodule

// File: tb/tb_expr_stream_ctrl.sv
// Directed plus randomized checks of expr_stream_ctrl against a pair-rule grammar model.
module tb_expr_stream_ctrl;

  typedef logic [7:0] ch_t;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       res_valid;
  logic       res_ok;
  logic [7:0] res_len;
  logic       res_ready = 1'b0;
  logic [15:0] ok_count;

  int n_assert = 0;
  int n_fail   = 0;
  int exp_cnt  = 0;

  expr_stream_ctrl #(.LEN_W(8), .DEPTH_W(3)) dut (
    .clk(clk), .clr(clr), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .res_valid(res_valid), .res_ok(res_ok), .res_len(res_len), .res_ready(res_ready),
    .ok_count(ok_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (observed running, required finished)");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Well-formed iff operands and operators alternate (start and end on operand side),
  // parentheses never dip below zero or above 7 at any prefix, and end balanced.
  function automatic void model(input ch_t q[$], output bit ok, output int len);
    bit have_operand = 0;
    int bal = 0;
    ok = 1;
    foreach (q[i]) begin
      ch_t c = q[i];
      if (c >= "0" && c <= "9") begin
        if (have_operand) ok = 0;
        have_operand = 1;
      end else if (c == "+" || c == "*") begin
        if (!have_operand) ok = 0;
        have_operand = 0;
      end else if (c == "(") begin
        if (have_operand) ok = 0;
        bal++;
        if (bal > 7) ok = 0;
      end else if (c == ")") begin
        if (!have_operand) ok = 0;
        bal--;
        if (bal < 0) ok = 0;
      end else begin
        ok = 0;
      end
    end
    if (!have_operand || bal != 0) ok = 0;
    len = (q.size() > 255) ? 255 : q.size();
  endfunction

  function automatic void str2q(input string s, output ch_t q[$]);
    q = {};
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
  endfunction

  task automatic send_char(input ch_t c);
    int n = 0;
    in_valid = 1'b1;
    in_data  = c;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 20) chk("in_ready_timeout", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic send_expr(input ch_t body[$], input int hold, input bit junk, input bit gaps,
                           input string tag);
    bit eok;
    int elen;
    logic [7:0] len_seen;
    model(body, eok, elen);
    foreach (body[i]) begin
      send_char(body[i]);
      if (gaps && $urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end
    send_char(";");
    if (eok) exp_cnt++;
    chk({tag, ".res_valid"}, res_valid, 1);
    chk({tag, ".in_ready"}, in_ready, 0);
    chk({tag, ".res_ok"}, res_ok, eok);
    chk({tag, ".res_len"}, res_len, elen);
    chk({tag, ".ok_count"}, ok_count, exp_cnt);
    len_seen = res_len;
    for (int k = 0; k < hold; k++) begin
      if (junk) begin
        in_valid = 1'b1;
        in_data  = "7";
      end
      @(posedge clk); #1;
      chk({tag, ".hold_valid"}, res_valid, 1);
      chk({tag, ".hold_ready"}, in_ready, 0);
      chk({tag, ".hold_ok"}, res_ok, eok);
      chk({tag, ".hold_len"}, res_len, len_seen);
    end
    in_valid  = 1'b0;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk({tag, ".after_ready"}, in_ready, 1);
    chk({tag, ".after_valid"}, res_valid, 0);
    chk({tag, ".after_count"}, ok_count, exp_cnt);
  endtask

  task automatic gen_random(output ch_t q[$]);
    int target = $urandom_range(0, 20);
    int d = 0;
    bit need_operand = 1;
    string junk = "0+*() a1";
    q = {};
    for (int i = 0; i < target; i++) begin
      if (need_operand) begin
        if (d < 7 && $urandom_range(0, 2) == 0) begin
          q.push_back("(");
          d++;
        end else begin
          q.push_back(8'("0" + $urandom_range(0, 9)));
          need_operand = 0;
        end
      end else if (d > 0 && $urandom_range(0, 1) == 0) begin
        q.push_back(")");
        d--;
      end else begin
        q.push_back($urandom_range(0, 1) ? "+" : "*");
        need_operand = 1;
      end
    end
    if (need_operand && target > 0) q.push_back("5");
    for (int i = 0; i < d; i++) q.push_back(")");
    if (q.size() > 0 && $urandom_range(0, 2) == 0)
      q[$urandom_range(0, q.size() - 1)] = junk[$urandom_range(0, junk.len() - 1)];
  endtask

  initial begin
    ch_t q[$];
    clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.in_ready", in_ready, 1);
    chk("reset.res_valid", res_valid, 0);
    chk("reset.res_ok", res_ok, 0);
    chk("reset.res_len", res_len, 0);
    chk("reset.ok_count", ok_count, 0);
    clr = 1'b1;

    str2q("1+2", q);        send_expr(q, 0, 0, 0, "simple");
    str2q("(1*(2+3))", q);  send_expr(q, 0, 0, 0, "nested");
    str2q("1+", q);         send_expr(q, 0, 0, 0, "dangling_op");
    q = {};                 send_expr(q, 0, 0, 0, "empty");

    q = {};
    for (int i = 0; i < 7; i++) q.push_back("(");
    q.push_back("1");
    for (int i = 0; i < 7; i++) q.push_back(")");
    send_expr(q, 0, 0, 0, "depth7");
    q = {};
    for (int i = 0; i < 8; i++) q.push_back("(");
    q.push_back("1");
    for (int i = 0; i < 8; i++) q.push_back(")");
    send_expr(q, 0, 0, 0, "depth8");
    str2q("1)", q);         send_expr(q, 0, 0, 0, "underflow");

    str2q("4*5", q);        send_expr(q, 5, 1, 0, "backpressure");
    str2q("1", q);          send_expr(q, 0, 0, 0, "post_bp");

    str2q("(1+", q);
    foreach (q[i]) send_char(q[i]);
    clr = 1'b0;
    @(posedge clk); #1;
    clr = 1'b1;
    exp_cnt = 0;
    chk("midreset.in_ready", in_ready, 1);
    chk("midreset.res_valid", res_valid, 0);
    chk("midreset.res_ok", res_ok, 0);
    chk("midreset.res_len", res_len, 0);
    chk("midreset.ok_count", ok_count, 0);
    str2q("2", q);          send_expr(q, 0, 0, 0, "after_reset");

    send_char("3");
    send_char(";");
    chk("rptreset.pre_valid", res_valid, 1);
    clr = 1'b0;
    @(posedge clk); #1;
    clr = 1'b1;
    exp_cnt = 0;
    chk("rptreset.res_valid", res_valid, 0);
    chk("rptreset.ok_count", ok_count, 0);
    chk("rptreset.in_ready", in_ready, 1);

    q = {"1"};
    while (q.size() < 299) begin
      q.push_back("+");
      q.push_back("1");
    end
    send_expr(q, 0, 0, 0, "saturate");
    str2q("1 +2", q);       send_expr(q, 0, 0, 0, "space");

    for (int r = 0; r < 40; r++) begin
      gen_random(q);
      send_expr(q, $urandom_range(0, 3), $urandom_range(0, 1), 1, "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
